// File: rtl/hermes_route_ctrl.sv
// hermes_route_ctrl: routing/arbitration controller for one 5-port Hermes router.
// It arbitrates the header requests round-robin, picks the output port by
// XY or YX dimension-order routing, programs the crossbar selects, tracks
// which outputs are busy and flags inputs that keep losing to busy outputs.
// Optional build macro HERMES_FORCE_IO_EN: a head flit with its MSB set can
// name the output port directly in bits [FLIT_SIZE-2:FLIT_SIZE-4].
module hermes_route_ctrl #(
    parameter int                  ADDR_W    = 8,
    parameter logic [2*ADDR_W-1:0] ADDRESS   = '0,
    parameter int                  FLIT_SIZE = 32,
    parameter bit                  ROUTE_YX  = 1'b0,
    parameter int                  STALL_MAX = 4,
    localparam int                 NPORT     = 5
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NPORT-1:0]                 req_i,
    input  logic [NPORT-1:0]                 sending_i,
    input  logic [NPORT-1:0][FLIT_SIZE-1:0]  data_i,
    output logic [NPORT-1:0]                 ack_o,
    output logic [NPORT-1:0]                 free_o,
    output logic [NPORT-1:0][2:0]            inport_o,
    output logic [NPORT-1:0][2:0]            outport_o,
    output logic [NPORT-1:0]                 stall_o
);

    localparam logic [2:0] P_EAST  = 3'd0;
    localparam logic [2:0] P_WEST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_LOCAL = 3'd4;

    localparam logic [ADDR_W-1:0] AX = ADDRESS[2*ADDR_W-1:ADDR_W];
    localparam logic [ADDR_W-1:0] AY = ADDRESS[ADDR_W-1:0];

    typedef enum logic [1:0] {S_WAIT, S_ARBIT, S_ROUTE, S_ACK} state_t;

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_sel, w_sel_nxt, w_arb, w_dir;
    logic                    w_found;
    logic [NPORT-1:0]        r_free, r_send, w_release;
    logic [NPORT-1:0][2:0]   r_inport, r_outport;
    logic [NPORT-1:0]        r_stall;
    logic                    w_claim, w_fail;
    logic [ADDR_W-1:0]       w_tx, w_ty;
    logic                    w_unused;

    // Wrap a port index that ran past LOCAL back to EAST.
    function automatic logic [2:0] f_wrap(input int v);
        return (v >= NPORT) ? 3'(v - NPORT) : 3'(v);
    endfunction

    assign w_tx     = data_i[r_sel][2*ADDR_W-1:ADDR_W];
    assign w_ty     = data_i[r_sel][ADDR_W-1:0];
    assign w_unused = ^data_i;

    // Round-robin search starting after the last selected port, sel itself last.
    always_comb begin
        w_found = 1'b0;
        w_arb   = r_sel;
        for (int k = 1; k <= NPORT; k++) begin
            if (!w_found && req_i[f_wrap(int'(r_sel) + k)]) begin
                w_found = 1'b1;
                w_arb   = f_wrap(int'(r_sel) + k);
            end
        end
    end

    // Dimension-order route of the selected head flit, optional forced port.
    always_comb begin
        w_dir = P_LOCAL;
        if (ROUTE_YX) begin
            if (w_ty != AY)      w_dir = (w_ty > AY) ? P_NORTH : P_SOUTH;
            else if (w_tx != AX) w_dir = (w_tx > AX) ? P_EAST  : P_WEST;
        end else begin
            if (w_tx != AX)      w_dir = (w_tx > AX) ? P_EAST  : P_WEST;
            else if (w_ty != AY) w_dir = (w_ty > AY) ? P_NORTH : P_SOUTH;
        end
`ifdef HERMES_FORCE_IO_EN
        // Forced codes 5..7 name no port, so normal routing stands.
        if (data_i[r_sel][FLIT_SIZE-1] && (data_i[r_sel][FLIT_SIZE-2 -: 3] < 3'd5))
            w_dir = data_i[r_sel][FLIT_SIZE-2 -: 3];
`endif
    end

    assign w_claim   = (r_state == S_ROUTE) && req_i[r_sel] &&  r_free[w_dir];
    assign w_fail    = (r_state == S_ROUTE) && req_i[r_sel] && !r_free[w_dir];
    assign w_release = r_send & ~sending_i;

    // Next-state logic of the arbitration FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            S_WAIT:  if (|req_i) w_state_nxt = S_ARBIT;
            S_ARBIT: begin
                w_sel_nxt   = w_arb;
                w_state_nxt = S_ROUTE;
            end
            S_ROUTE: begin
                if (!req_i[r_sel])      w_state_nxt = S_WAIT;
                else if (r_free[w_dir]) w_state_nxt = S_ACK;
                else                    w_state_nxt = S_ARBIT;
            end
            S_ACK:   w_state_nxt = S_WAIT;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // FSM state and selected input register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_WAIT;
            r_sel   <= P_EAST;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Crossbar programming and output occupancy; a claim needs a free port,
    // so it never collides with a release of the same port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_free    <= '1;
            r_send    <= '0;
            r_inport  <= '0;
            r_outport <= '0;
        end else begin
            r_send <= sending_i;
            r_free <= r_free | w_release;
            if (w_claim) begin
                r_free[w_dir]    <= 1'b0;
                r_outport[r_sel] <= w_dir;
                r_inport[w_dir]  <= r_sel;
            end
        end
    end

    generate
        if (STALL_MAX > 0) begin : g_stall
            localparam int CW = $clog2(STALL_MAX + 1);
            logic [NPORT-1:0][CW-1:0] r_cnt, w_cnt_nxt;

            // Per-input count of consecutive failed route attempts.
            always_comb begin
                w_cnt_nxt = r_cnt;
                for (int i = 0; i < NPORT; i++) begin
                    if (!req_i[i] || (w_claim && r_sel == 3'(i)))
                        w_cnt_nxt[i] = '0;
                    else if (w_fail && r_sel == 3'(i) && r_cnt[i] != CW'(STALL_MAX))
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end

            // Counters and the registered starvation flags.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt   <= '0;
                    r_stall <= '0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                    for (int i = 0; i < NPORT; i++)
                        r_stall[i] <= (w_cnt_nxt[i] == CW'(STALL_MAX));
                end
            end
        end else begin : g_nostall
            // Stall tracking disabled: flags stay low.
            always_ff @(posedge clk_i) begin
                r_stall <= '0;
            end
        end
    endgenerate

    assign ack_o     = (r_state == S_ACK) ? (NPORT'(1) << r_sel) : '0;
    assign free_o    = r_free;
    assign inport_o  = r_inport;
    assign outport_o = r_outport;
    assign stall_o   = r_stall;

endmodule

// File: tb/tb_hermes_route_ctrl.sv
// Bench for hermes_route_ctrl: directed and random request rounds, a
// scoreboard queue filled at issue time and drained by an ack monitor.
module tb_hermes_route_ctrl;

    localparam int          AW   = 8;
    localparam int          FS   = 32;
    localparam int          SMAX = 4;
    localparam bit          YX   = 1'b0;
    localparam logic [15:0] ADDR = 16'h0101;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [4:0]            req = '0;
    logic [4:0]            sending = '0;
    logic [4:0][FS-1:0]    data = '0;
    logic [4:0]            ack, free, stall;
    logic [4:0][2:0]       inport, outport;

    hermes_route_ctrl #(
        .ADDR_W(AW), .ADDRESS(ADDR), .FLIT_SIZE(FS), .ROUTE_YX(YX), .STALL_MAX(SMAX)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .sending_i(sending), .data_i(data),
        .ack_o(ack), .free_o(free), .inport_o(inport), .outport_o(outport), .stall_o(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int port; int dir; int cyc; } exp_t;
    exp_t q[$];
    exp_t me;
    int checks = 0, errors = 0, ack_cnt = 0, ptr = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference route: signed coordinate differences decide the direction.
    function automatic int model_dir(input logic [FS-1:0] f);
        int dx, dy;
`ifdef HERMES_FORCE_IO_EN
        if (f[FS-1] && int'(f[FS-2 -: 3]) < 5) return int'(f[FS-2 -: 3]);
`endif
        dx = int'(f[15:8]) - int'(ADDR[15:8]);
        dy = int'(f[7:0])  - int'(ADDR[7:0]);
        if (!YX) begin
            if (dx != 0) return (dx > 0) ? 0 : 1;
            if (dy != 0) return (dy > 0) ? 2 : 3;
        end else begin
            if (dy != 0) return (dy > 0) ? 2 : 3;
            if (dx != 0) return (dx > 0) ? 0 : 1;
        end
        return 4;
    endfunction

    // Monitor: every grant is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && ack != 0) begin
            ack_cnt++;
            check("ack_onehot", $countones(ack), 1);
            if (q.size() == 0) begin
                check("unexpected_ack", int'(ack), 0);
            end else begin
                me = q.pop_front();
                check("ack_port", int'(ack), 1 << me.port);
                check("outport", int'(outport[me.port]), me.dir);
                check("inport", int'(inport[me.dir]), me.port);
                check("free_claimed", int'(free[me.dir]), 0);
                if (me.cyc >= 0) check("ack_latency", cyc, me.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; sending = '0;
        tick(); tick();
        rst = 1'b0; ptr = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_free"}, int'(free), 5'h1f);
        check({tag, "_inport"}, int'(inport), 0);
        check({tag, "_outport"}, int'(outport), 0);
        check({tag, "_ack"}, int'(ack), 0);
        check({tag, "_stall"}, int'(stall), 0);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (q.size() != 0 && c < budget) begin
            @(negedge clk); #1; c++;
        end
        if (q.size() != 0) begin
            check("grant_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic release_ports(input logic [4:0] m);
        tick(); sending = m;
        tick(); sending = '0;
        tick();
        check("release_free", int'(free), 5'h1f);
    endtask

    // One round: hold all requests in mask, expect round-robin grants 4 cycles apart.
    task automatic run_round(input logic [4:0] mask, input logic [4:0][FS-1:0] flits);
        logic [4:0] rem = mask, outs = '0;
        int k0 = cyc, n = 0, d;
        data = flits;
        while (rem != 0) begin
            for (int k = 1; k <= 5; k++) begin
                if (rem[(ptr + k) % 5]) begin
                    ptr = (ptr + k) % 5;
                    d = model_dir(flits[ptr]);
                    q.push_back('{ptr, d, k0 + 3 + 4 * n});
                    outs[d] = 1'b1; rem[ptr] = 1'b0; n++;
                    break;
                end
            end
        end
        req = mask;
        wait_drain(60);
        req = '0;
        release_ports(outs);
    endtask

    logic [4:0][FS-1:0] fl;
    logic [4:0]         msk, used;
    int k0, a0, sc, d;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        check_idle("reset");

        // Single LOCAL request towards the east neighbour.
        fl = '0; fl[4] = 32'h0000_0301;
        run_round(5'b10000, fl);
        // Diagonal target: EAST under XY, NORTH under YX.
        fl[4] = 32'h0000_0203;
        run_round(5'b10000, fl);

        // Three simultaneous requesters from a fresh pointer.
        do_reset();
        fl = '0; fl[0] = 32'h0000_0100; fl[2] = 32'h0000_0101; fl[4] = 32'h0000_0001;
        run_round(5'b10101, fl);

        // Forced output field, then a forced code with no port behind it.
        fl = '0; fl[3] = 32'hB000_0101;
        run_round(5'b01000, fl);
        fl[3] = 32'hE000_0101;
        run_round(5'b01000, fl);

        // Starvation: EAST kept busy while WEST asks for it.
        fl = '0; fl[4] = 32'h0000_0301;
        data = fl; ptr = 4;
        q.push_back('{4, model_dir(fl[4]), cyc + 3});
        req = 5'b10000;
        wait_drain(20);
        req = '0; sending = 5'b00001;
        tick(); tick();
        fl[1] = 32'h0000_0301; data = fl;
        k0 = cyc; a0 = ack_cnt; sc = -1;
        q.push_back('{1, model_dir(fl[1]), -1}); ptr = 1;
        req = 5'b00010;
        for (int c = 0; c < 30 && sc < 0; c++) begin
            @(negedge clk);
            if (stall[1]) sc = cyc;
        end
        check("stall_rise_cycle", sc, k0 + 1 + 2 * SMAX);
        repeat (6) tick();
        check("stall_saturated", int'(stall[1]), 1);
        check("no_ack_while_busy", ack_cnt, a0);
        sending = '0;
        tick();
        check("release_next_cycle", int'(free[0]), 1);
        wait_drain(20);
        check("stall_cleared_on_grant", int'(stall[1]), 0);
        req = '0;
        release_ports(5'b00001);

        // Reset while the FSM sits in ROUTE.
        fl = '0; fl[4] = 32'h0000_0301; data = fl;
        a0 = ack_cnt;
        req = 5'b10000;
        tick(); tick();
        rst = 1'b1;
        tick();
        check_idle("reset_in_route");
        rst = 1'b0; req = '0; ptr = 0;
        tick(); tick(); tick(); tick();
        check("no_ack_after_abort", ack_cnt, a0);
        check("free_after_abort", int'(free), 5'h1f);

        // Random rounds with distinct target outputs per round.
        for (int r = 0; r < 40; r++) begin
            msk = 5'($urandom_range(1, 31)); used = '0; fl = '0;
            for (int i = 0; i < 5; i++) begin
                fl[i] = $urandom;
                if ($urandom_range(0, 3) != 0)
                    fl[i][15:0] = {6'd0, 2'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3))};
                d = model_dir(fl[i]);
                if (msk[i]) begin
                    if (used[d]) msk[i] = 1'b0;
                    else used[d] = 1'b1;
                end
            end
            if (msk != 0) run_round(msk, fl);
        end

        check("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hermes_route_ctrl.md
Name: hermes_route_ctrl

Overview:
- Parametrised next-generation routing/arbitration controller for one Hermes 5-port router (EAST, WEST, NORTH, SOUTH, LOCAL).
- Arbitrates header requests round-robin, computes the output port with XY or YX dimension-order routing over configurable address widths, and programs the crossbar mux selects.
- Tracks output-port occupancy and flags inputs starved by repeatedly busy outputs.
- Sits beside the input buffers and crossbar inside the router top.

Parameters:
- ADDR_W, 8, width of each coordinate; node address and header target are 2*ADDR_W bits, X in the upper half.
- ADDRESS, 0, this router's address, [2*ADDR_W-1:0].
- FLIT_SIZE, 32, flit width; minimum 2*ADDR_W+4.
- ROUTE_YX, 0, 0 = XY routing, 1 = YX routing.
- STALL_MAX, 4, consecutive failed route attempts before stall_o asserts; 0 disables stall tracking.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset.
- req_i, input, [NPORT], header-present request per input port.
- sending_i, input, [NPORT], output port i still transmitting a packet.
- data_i, input, [NPORT][FLIT_SIZE], head flit per input port.
- ack_o, output, [NPORT], one-cycle header grant.
- free_o, output, [NPORT], output port i unallocated.
- inport_o, output, [NPORT] hermes_port_t, input driving output i.
- outport_o, output, [NPORT] hermes_port_t, output taken by input i.
- stall_o, output, [NPORT], input i starved.

Interface decisions:
- One clock; reset is synchronous and active-high.
- NPORT = 5; port encoding EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - state WAIT, sel = EAST.
  - free_o all 1; inport_o/outport_o all EAST; ack_o 0; stall_o 0; stall counters 0.
  - Reset asserted mid-operation aborts any arbitration; no partial mux programming survives.
- FSM states and transitions:
  - WAIT: leave to ARBIT if any req_i is high.
  - ARBIT: latch sel = first requester searching sel+1 .. 4, then 0 .. sel (sel itself last); go to ROUTE.
  - ROUTE:
    - If req_i[sel] = 0: go to WAIT, nothing programmed.
    - Else if free_o[dir] = 1: outport_o[sel] <= dir, inport_o[dir] <= sel, free_o[dir] <= 0; go to ACK.
    - Else: go to ARBIT (failed attempt).
  - ACK: ack_o[sel] = 1 for exactly this cycle; go to WAIT.
  - Illegal encodings recover to WAIT.
- Latency: req_i high in WAIT at cycle t gives ARBIT at t+1, ROUTE at t+2, ack_o at t+3 when the output is free.
- Routing (dir):
  - tx/ty = data_i[sel][2*ADDR_W-1:ADDR_W] / [ADDR_W-1:0]; ax/ay likewise from ADDRESS.
  - XY: tx != ax gives EAST if tx > ax, else WEST. Otherwise ty != ay gives NORTH if ty > ay, else SOUTH. Otherwise LOCAL.
  - YX: same rule, Y dimension first.
  - Comparisons are unsigned.
- Release:
  - sending_i is registered each cycle. A 1 to 0 transition on sending_i[i] sets free_o[i] = 1 on the following edge.
  - Release and claim of the same port cannot coincide, because a claim requires free_o = 1. Multiple releases in one cycle all apply.
- Stall tracking:
  - Per-input counter increments on each failed ROUTE for that input and saturates at STALL_MAX.
  - stall_o[i] = (count == STALL_MAX), registered.
  - Counter clears on grant of input i or whenever req_i[i] = 0.
  - STALL_MAX = 0 holds stall_o at 0.
- Grant exclusivity: ack_o is never high on more than one port.

Optional Feature:
- Macro HERMES_FORCE_IO_EN.
- Defined:
  - Head flit bit FLIT_SIZE-1 = 1 forces output = data_i[sel][FLIT_SIZE-2:FLIT_SIZE-4], bypassing the routing algorithm.
  - Forced values 5..7 are ignored and normal routing is used.
  - Free check, release and stall rules are unchanged.
- Undefined: those bits are ignored; routing is always XY/YX.

Test Plan:
- Reset, then req_i[LOCAL]=1, ADDRESS=0x0101, target 0x0301, XY: ack_o[4] at t+3, outport_o[4]=EAST, inport_o[0]=LOCAL, free_o[0]=0.
- Same target 0x0203 with ROUTE_YX=1: output NORTH. With ROUTE_YX=0: output EAST.
- req_i[0], [2] and [4] held high, all outputs free, sel=EAST initially: grants in order NORTH, LOCAL, EAST; one ack per 4-cycle round.
- Output EAST held busy (sending_i[0]=1), STALL_MAX=4, WEST requests east: no ack, stall_o[1]=1 after 4th failed ROUTE. Drop sending_i[0]: free_o[0]=1 next cycle, then grant, and stall_o[1] clears.
- Assert rst_i during ROUTE: next cycle all outputs at reset values, no ack. With HERMES_FORCE_IO_EN, header bit31=1, force=SOUTH, target local: output SOUTH. Force=6: normal routing.
